// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for seq_alu. Holds the opcode and FSM state
//                encodings, the flag bit positions and a flag-packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_UMUL = 3'd3,
    OP_SMUL = 3'd4,
    OP_AND  = 3'd5,
    OP_XOR  = 3'd6,
    OP_CMP  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the 4-bit flags word {negative, overflow, carry, zero}
  localparam int unsigned c_flag_zero  = 0;
  localparam int unsigned c_flag_carry = 1;
  localparam int unsigned c_flag_ovf   = 2;
  localparam int unsigned c_flag_neg   = 3;

  function automatic logic [3:0] pack_flags(input logic i_neg, input logic i_ovf,
                                            input logic i_carry, input logic i_zero);
    logic [3:0] w_f;
    w_f               = 4'b0000;
    w_f[c_flag_neg]   = i_neg;
    w_f[c_flag_ovf]   = i_ovf;
    w_f[c_flag_carry] = i_carry;
    w_f[c_flag_zero]  = i_zero;
    return w_f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Unsigned iterative shift-add multiplier. A start pulse loads
//                the operands and a W-step counter; one partial product is
//                accumulated per cycle. o_done is high during the final step,
//                with o_product already holding the completed product, so the
//                caller can register the result on that same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int c_cnt_w = $clog2(W + 1);

  logic [2*W-1:0]     r_acc;
  logic [2*W-1:0]     r_mcand;
  logic [W-1:0]       r_mplier;
  logic [c_cnt_w-1:0] r_cnt;

  logic [2*W-1:0]     w_addend;
  logic [2*W-1:0]     w_acc_next;
  logic               w_busy;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_busy     = (r_cnt != '0);
  assign o_done     = (r_cnt == c_cnt_w'(1));
  assign o_product  = w_acc_next;

  // Load on start, otherwise step the shift-add recurrence while the counter runs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= c_cnt_w'(W);
    end else if (w_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Clocked integer ALU with valid/ready on both sides. Single-
//                cycle ops are computed at accept and registered straight into
//                the result; UMUL/SMUL run on seq_multiplier for W cycles.
//                SMUL multiplies magnitudes and negates the product afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     opcode,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [3:0]     flags
);

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [2*W-1:0] r_result;
  logic [3:0]     r_flags;
  logic           r_neg_prod;
  logic           r_is_smul;

  opcode_t        w_op;
  logic           w_accept;
  logic           w_is_mul;
  logic           w_is_smul;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_mul_start;
  logic           w_mul_done;
  logic [2*W-1:0] w_product;
  logic [2*W-1:0] w_mul_res;
  logic [3:0]     w_mul_flags;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_diff;
  logic [2*W-1:0] w_sc_result;
  logic [3:0]     w_sc_flags;

  assign w_op      = opcode_t'(opcode);
  assign w_accept  = in_valid & r_in_ready;
  assign w_is_smul = (w_op == OP_SMUL);
  assign w_is_mul  = (w_op == OP_UMUL) || w_is_smul;

  // Signed multiply feeds the unsigned core with operand magnitudes;
  // the magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  assign w_mag_a     = (w_is_smul && op_a[W-1]) ? -op_a : op_a;
  assign w_mag_b     = (w_is_smul && op_b[W-1]) ? -op_b : op_b;
  assign w_mul_start = w_accept & w_is_mul;

  seq_multiplier #(.W(W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (w_mag_a),
    .i_b       (w_mag_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  assign w_mul_res   = r_neg_prod ? -w_product : w_product;
  assign w_mul_flags = pack_flags(r_is_smul & w_mul_res[2*W-1], 1'b0, 1'b0,
                                  (w_mul_res == '0));

  assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
  assign w_diff = op_a - op_b;

  // Single-cycle datapath: evaluated on the live operands, captured only at accept
  always_comb begin
    logic w_neg;
    logic w_ovf;
    logic w_carry;
    w_sc_result = '0;
    w_neg       = 1'b0;
    w_ovf       = 1'b0;
    w_carry     = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sc_result = {{W{1'b0}}, w_sum[W-1:0]};
        w_carry     = w_sum[W];
        w_ovf       = (op_a[W-1] == op_b[W-1]) && (w_sum[W-1] != op_a[W-1]);
        w_neg       = w_sum[W-1];
      end
      OP_SUB: begin
        w_sc_result = {{W{1'b0}}, w_diff};
        w_carry     = (op_a < op_b);
        w_ovf       = (op_a[W-1] != op_b[W-1]) && (w_diff[W-1] != op_a[W-1]);
        w_neg       = w_diff[W-1];
      end
      OP_AND:  w_sc_result = {{W{1'b0}}, op_a & op_b};
      OP_XOR:  w_sc_result = {{W{1'b0}}, op_a ^ op_b};
      OP_CMP:  w_sc_result[2:0] = {op_a > op_b, op_a == op_b, op_a < op_b};
      default: w_sc_result = '0;
    endcase
    w_sc_flags = pack_flags(w_neg, w_ovf, w_carry, (w_sc_result == '0));
  end

  // Control FSM with registered handshake outputs and result/flags capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_neg_prod  <= 1'b0;
      r_is_smul   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_is_mul) begin
              r_state    <= ST_MUL;
              r_is_smul  <= w_is_smul;
              r_neg_prod <= w_is_smul & (op_a[W-1] ^ op_b[W-1]);
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_sc_result;
              r_flags     <= w_sc_flags;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_flags     <= w_mul_flags;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule
`default_nettype wire
